// File: rtl/mario_sprite_pkg.sv
// Shared constants, types and the frame base table for the Mario sprite renderer.
package mario_sprite_pkg;

  localparam int SPR_W      = 20;
  localparam int SPR_H      = 40;
  localparam int SPR_SIZE   = SPR_W * SPR_H;
  localparam int NUM_FRAMES = 3;
  localparam int FRAME_HOLD = 6;
  localparam int ADDR_W     = 19;
  localparam int IDX_W      = 4;

  localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'h0;

  typedef logic [1:0] anim_frame_t;

  // Frames are stored back to back; a constant table keeps multipliers out of the address path.
  function automatic logic [ADDR_W-1:0] frame_base(input anim_frame_t frame);
    logic [ADDR_W-1:0] base;
    case (frame)
      2'd0:    base = '0;
      2'd1:    base = ADDR_W'(SPR_SIZE);
      2'd2:    base = ADDR_W'(2 * SPR_SIZE);
      default: base = '0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/mario_anim_seq.sv
// Jump animation sequencer: advances the sprite frame every FRAME_HOLD video
// frames while airborne, and snaps back to frame 0 on the first tick after landing.
//
// anim_frame | meaning
// 0          | standing / take-off pose (also forced whenever not jumping at a tick)
// 1          | mid-jump pose
// 2          | apex pose, wraps back to 0 after its hold time
module mario_anim_seq
  import mario_sprite_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       frame_tick,
  input  logic       jumping,
  output logic [1:0] anim_frame
);

  localparam logic [2:0] HOLD_LAST  = 3'(FRAME_HOLD - 1);
  localparam logic [1:0] FRAME_LAST = 2'(NUM_FRAMES - 1);

  logic [2:0]  r_hold_cnt;
  anim_frame_t r_frame;
  logic [2:0]  w_hold_cnt_nxt;
  anim_frame_t w_frame_nxt;

  // Next-state: only a frame_tick can move the sequencer, so jumping is effectively sampled per video frame.
  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    w_frame_nxt    = r_frame;
    if (frame_tick) begin
      if (!jumping) begin
        w_hold_cnt_nxt = '0;
        w_frame_nxt    = '0;
      end else if (r_hold_cnt == HOLD_LAST) begin
        w_hold_cnt_nxt = '0;
        w_frame_nxt    = (r_frame == FRAME_LAST) ? 2'd0 : r_frame + 2'd1;
      end else begin
        w_hold_cnt_nxt = r_hold_cnt + 3'd1;
      end
    end
  end

  // Hold counter and frame register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hold_cnt <= '0;
      r_frame    <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
      r_frame    <= w_frame_nxt;
    end
  end

  assign anim_frame = r_frame;

endmodule

// File: rtl/mario_sprite_renderer.sv
// Mario sprite renderer: turns the raster position into a sprite RAM address and
// gates the returned palette index into a per-pixel index plus opaque flag.
// Latency from DrawX/DrawY to pixel_* is two edges: one for the address register,
// one for the RAM's synchronous read; the output gating uses the registered hit flag.
module mario_sprite_renderer
  import mario_sprite_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        frame_tick,
  input  logic        jumping,
  input  logic        facing_left,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  MarioX,
  input  logic [9:0]  MarioY,
  output logic [18:0] READ_ADDR,
  input  logic [3:0]  data_out,
  output logic [3:0]  pixel_idx,
  output logic        pixel_valid,
  output logic [1:0]  anim_frame
);

  logic [1:0]        w_anim_frame;
  logic [10:0]       w_dx;
  logic [10:0]       w_dy;
  logic              w_hit;
  logic [4:0]        w_col;
  logic [ADDR_W-1:0] w_dy_ext;
  logic [ADDR_W-1:0] w_row_off;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_read_addr;
  logic              r_hit_s1;
  logic              r_hit_s2;

  mario_anim_seq u_anim_seq (
    .CLK        (CLK),
    .RESET      (RESET),
    .frame_tick (frame_tick),
    .jumping    (jumping),
    .anim_frame (w_anim_frame)
  );

  // Bit 10 is the borrow: a raster position left of / above the sprite is a miss, never a wrap.
  assign w_dx = {1'b0, DrawX} - {1'b0, MarioX};
  assign w_dy = {1'b0, DrawY} - {1'b0, MarioY};

  assign w_hit = !w_dx[10] && !w_dy[10] &&
                 (w_dx[9:0] < 10'(SPR_W)) && (w_dy[9:0] < 10'(SPR_H));

  // Only meaningful on a hit, where dx < 20 and dy < 40 fit the narrowed fields.
  assign w_col     = facing_left ? (5'(SPR_W - 1) - w_dx[4:0]) : w_dx[4:0];
  assign w_dy_ext  = ADDR_W'(w_dy[5:0]);
  assign w_row_off = (w_dy_ext << 4) + (w_dy_ext << 2);
  assign w_addr    = frame_base(w_anim_frame) + w_row_off + ADDR_W'(w_col);

  // Stage 0/1 registers; the address is held on a miss so the RAM sees no needless toggling.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_read_addr <= '0;
      r_hit_s1    <= 1'b0;
      r_hit_s2    <= 1'b0;
    end else begin
      if (w_hit) begin
        r_read_addr <= w_addr;
      end
      r_hit_s1 <= w_hit;
      r_hit_s2 <= r_hit_s1;
    end
  end

  assign READ_ADDR   = r_read_addr;
  assign pixel_idx   = r_hit_s2 ? data_out : '0;
  assign pixel_valid = r_hit_s2 && (data_out != TRANSPARENT_IDX);
  assign anim_frame  = w_anim_frame;

endmodule

// File: tb/tb_mario_sprite_renderer.sv
// Bench for the Mario sprite renderer: directed literal checks plus randomized
// raster traffic compared every cycle against an arithmetic reference model.
module tb_mario_sprite_renderer;

  logic        CLK;
  logic        RESET;
  logic        frame_tick;
  logic        jumping;
  logic        facing_left;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  MarioX;
  logic [9:0]  MarioY;
  logic [18:0] READ_ADDR;
  logic [3:0]  data_out;
  logic [3:0]  pixel_idx;
  logic        pixel_valid;
  logic [1:0]  anim_frame;

  logic [3:0] mem [0:2399];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // reference model state
  int m_addr, m_a1, m_a2, m_frame, m_cnt, m_dx, m_dy;
  bit m_h1, m_h2, m_hit;

  mario_sprite_renderer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .frame_tick  (frame_tick),
    .jumping     (jumping),
    .facing_left (facing_left),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .MarioX      (MarioX),
    .MarioY      (MarioY),
    .READ_ADDR   (READ_ADDR),
    .data_out    (data_out),
    .pixel_idx   (pixel_idx),
    .pixel_valid (pixel_valid),
    .anim_frame  (anim_frame)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // sprite RAM with one-cycle synchronous read
  always @(posedge CLK)
    data_out <= (READ_ADDR < 19'd2400) ? mem[READ_ADDR] : 4'h0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: addresses from plain arithmetic, two-deep delay for the pixel result.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_addr = 0; m_a1 = 0; m_a2 = 0; m_h1 = 0; m_h2 = 0;
      m_frame = 0; m_cnt = 0;
    end else begin
      m_dx  = int'(DrawX) - int'(MarioX);
      m_dy  = int'(DrawY) - int'(MarioY);
      m_hit = (m_dx >= 0) && (m_dx < 20) && (m_dy >= 0) && (m_dy < 40);
      m_h2 = m_h1;
      m_a2 = m_a1;
      if (m_hit)
        m_addr = m_frame * 800 + m_dy * 20 + (facing_left ? (19 - m_dx) : m_dx);
      m_h1 = m_hit;
      m_a1 = m_addr;
      if (frame_tick) begin
        if (!jumping) begin
          m_frame = 0; m_cnt = 0;
        end else if (m_cnt == 5) begin
          m_cnt = 0; m_frame = (m_frame + 1) % 3;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, just after the active edge settles.
  always begin
    @(posedge CLK);
    #1;
    if (chk_en) begin
      check("addr", int'(READ_ADDR), m_addr);
      check("pixel_idx", int'(pixel_idx), m_h2 ? int'(mem[m_a2]) : 0);
      check("pixel_valid", int'(pixel_valid), (m_h2 && mem[m_a2] != 4'h0) ? 1 : 0);
      check("anim_frame", int'(anim_frame), m_frame);
    end
  end

  task automatic set_px(input int mx, input int my, input int dx, input int dy, input bit fl);
    MarioX = 10'(mx); MarioY = 10'(my); DrawX = 10'(dx); DrawY = 10'(dy); facing_left = fl;
  endtask

  task automatic tick();
    @(negedge CLK); frame_tick = 1;
    @(negedge CLK); frame_tick = 0;
  endtask

  initial begin
    for (int i = 0; i < 2400; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[205]  = 4'h7;
    mem[214]  = 4'h3;
    mem[206]  = 4'h0;
    mem[1805] = 4'h9;
    mem[1005] = 4'h5;

    RESET = 1; frame_tick = 0; jumping = 0;
    set_px(0, 0, 700, 700, 0);
    @(negedge CLK); @(negedge CLK);
    check("reset_addr", int'(READ_ADDR), 0);
    check("reset_idx", int'(pixel_idx), 0);
    check("reset_valid", int'(pixel_valid), 0);
    check("reset_frame", int'(anim_frame), 0);
    RESET = 0;
    chk_en = 1;

    // hit, facing right, frame 0
    set_px(100, 200, 105, 210, 0);
    @(negedge CLK); check("hit_addr", int'(READ_ADDR), 205);
    @(negedge CLK); check("hit_idx", int'(pixel_idx), 7);
    check("hit_valid", int'(pixel_valid), 1);

    // mirrored
    facing_left = 1;
    @(negedge CLK); check("mirror_addr", int'(READ_ADDR), 214);
    @(negedge CLK); check("mirror_idx", int'(pixel_idx), 3);

    // misses left of and beyond the sprite hold the address
    DrawX = 10'd99;
    @(negedge CLK); check("missL_addr", int'(READ_ADDR), 214);
    @(negedge CLK); check("missL_valid", int'(pixel_valid), 0);
    check("missL_idx", int'(pixel_idx), 0);
    DrawX = 10'd120;
    @(negedge CLK); check("missR_addr", int'(READ_ADDR), 214);
    @(negedge CLK); check("missR_valid", int'(pixel_valid), 0);

    // transparent pixel
    set_px(100, 200, 106, 210, 0);
    @(negedge CLK); check("transp_addr", int'(READ_ADDR), 206);
    @(negedge CLK); check("transp_valid", int'(pixel_valid), 0);

    // animation: 18 ticks while jumping, frame 2 address checked on the way
    set_px(100, 200, 105, 210, 0);
    jumping = 1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check("anim_step", int'(anim_frame), (k / 6) % 3);
      if (k == 12) begin
        @(negedge CLK); check("frame2_addr", int'(READ_ADDR), 1805);
        @(negedge CLK); check("frame2_idx", int'(pixel_idx), 9);
      end
    end

    // landing between ticks takes effect only at the next tick
    for (int k = 0; k < 7; k++) tick();
    check("pre_land_frame", int'(anim_frame), 1);
    jumping = 0;
    repeat (3) @(negedge CLK);
    check("land_hold_frame", int'(anim_frame), 1);
    tick();
    check("land_frame", int'(anim_frame), 0);

    // reset mid-stream with a visible pixel and a nonzero frame
    jumping = 1;
    for (int k = 0; k < 6; k++) tick();
    @(negedge CLK); @(negedge CLK);
    check("pre_rst_valid", int'(pixel_valid), 1);
    check("pre_rst_addr", int'(READ_ADDR), 1005);
    @(negedge CLK);
    RESET = 1;
    #1;
    check("rst_addr", int'(READ_ADDR), 0);
    check("rst_idx", int'(pixel_idx), 0);
    check("rst_valid", int'(pixel_valid), 0);
    check("rst_frame", int'(anim_frame), 0);
    @(negedge CLK); RESET = 0;
    @(negedge CLK); check("resume_addr", int'(READ_ADDR), 205);
    @(negedge CLK); check("resume_idx", int'(pixel_idx), 7);
    check("resume_valid", int'(pixel_valid), 1);
    check("resume_frame", int'(anim_frame), 0);

    // randomized raster traffic around the sprite, including the right screen edge
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0) MarioX = 10'($urandom_range(625, 639));
      else MarioX = 10'($urandom_range(0, 639));
      MarioY = 10'($urandom_range(0, 470));
      DrawX  = 10'(int'(MarioX) + int'($urandom_range(0, 26)) - 3);
      DrawY  = 10'(int'(MarioY) + int'($urandom_range(0, 46)) - 3);
      facing_left = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 30) == 0) jumping = ~jumping;
      frame_tick = ($urandom_range(0, 7) == 0);
      RESET = ($urandom_range(0, 600) == 0);
    end
    @(negedge CLK);
    RESET = 0; frame_tick = 0;
    repeat (3) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mario_sprite_renderer.md
Name: mario_sprite_renderer

Overview:
- Sits directly downstream of the Mario sprite RAM.
- Converts the VGA raster position plus Mario's position, facing and jump state into a sprite RAM read address, then consumes the RAM's palette index.
- Outputs a per-pixel palette index and an opaque flag to the colour mapper.
- Contains the jump-animation frame sequencer (3 frames of 20x40), frame changes applied only at video-frame boundaries.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- NUM_FRAMES, 3, animation frames stored back-to-back in the RAM (base = frame*SPR_W*SPR_H)
- FRAME_HOLD, 6, frame_tick pulses each animation frame is shown
- TRANSPARENT_IDX, 4'h0, palette index treated as transparent (pink key)

Ports:
- CLK  in  1  system clock (pixel-rate domain shared with the sprite RAM)
- RESET  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
- jumping  in  1  Mario airborne
- facing_left  in  1  mirror sprite horizontally
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- MarioX  in  10  sprite top-left column
- MarioY  in  10  sprite top-left row
- READ_ADDR  out  19  registered read address to the sprite RAM
- data_out  in  4  palette index returned by the RAM (1-cycle synchronous read)
- pixel_idx  out  4  palette index for the raster position presented 2 cycles earlier
- pixel_valid  out  1  1 = sprite covers that pixel and the index is not TRANSPARENT_IDX
- anim_frame  out  2  current animation frame (0..NUM_FRAMES-1)

Behaviour:
- Reset (async, active-high): READ_ADDR=0, pixel_idx=0, pixel_valid=0, anim_frame=0, hold counter=0, pipeline hit flags=0. Assertion mid-line clears all outputs immediately; first valid output is 2 cycles after release.
- Sequencer state changes only on cycles where frame_tick=1:
  - jumping=0: anim_frame←0, counter←0.
  - jumping=1, counter==FRAME_HOLD-1: counter←0, anim_frame←(anim_frame==NUM_FRAMES-1)?0:anim_frame+1.
  - Otherwise: counter←counter+1.
  - jumping changes between ticks have no effect until the next tick.
- Stage 0 (combinational → registered at the edge):
  - dx = DrawX−MarioX, dy = DrawY−MarioY, 11-bit with borrow.
  - hit = no borrow on either, dx<SPR_W, and dy<SPR_H.
  - col = facing_left ? SPR_W−1−dx : dx.
  - READ_ADDR ← base(anim_frame) + dy*SPR_W + col.
  - base comes from a constant table (0, 800, 1600); dy*20 is computed as (dy<<4)+(dy<<2); no multipliers.
  - On miss, READ_ADDR is held at its previous value and hit_s1←0.
- Stage 1: hit_s2←hit_s1, which aligns with the RAM's registered data_out.
- Output register:
  - pixel_idx ← hit_s2 ? data_out : 0.
  - pixel_valid ← hit_s2 && data_out!=TRANSPARENT_IDX.
  - Fixed latency of 2 CLK edges from DrawX/DrawY to pixel_*.
- Boundaries:
  - MarioX near 639: dx overflow beyond SPR_W is a miss, with no wrap to column 0.
  - MarioX>DrawX is a borrow, so a miss.
  - anim_frame sampled in stage 0 belongs to the pixel's address; a tick mid-line may change frame, and tearing is accepted only within the tick cycle.
- RAM write port is not driven by this block.

Decomposition:
- Package mario_sprite_pkg holds:
  - SPR_W, SPR_H, SPR_SIZE=800, NUM_FRAMES, ADDR_W=19, IDX_W=4
  - frame base table function
  - anim_frame_t typedef (2-bit)
- Sub-module mario_anim_seq contains the FRAME_HOLD counter and frame register (inputs CLK, RESET, frame_tick, jumping; output anim_frame).
- The address pipeline stays in the top module.

Test Plan:
- Hit, facing right, frame 0:
  - Stimulus: MarioX=100, MarioY=200, DrawX=105, DrawY=210, facing_left=0.
  - Response: READ_ADDR=205 after 1 edge; RAM value 4'h7 gives pixel_idx=7, pixel_valid=1 after 2 edges.
- Mirror: same position with facing_left=1 → READ_ADDR=214.
- Frame 2: same pixel with anim_frame=2 → READ_ADDR=1805.
- Miss and transparency:
  - DrawX=99 or DrawX=120 → pixel_valid=0, pixel_idx=0, READ_ADDR unchanged.
  - Hit pixel whose RAM contents are 4'h0 → pixel_valid=0.
- Animation:
  - jumping=1, FRAME_HOLD=6: anim_frame becomes 1 at the 6th tick, 2 at the 12th, 0 at the 18th.
  - jumping→0 between ticks: anim_frame stays until the next tick, then becomes 0.
- Reset mid-stream: RESET pulsed while pixel_valid=1 → all outputs 0 immediately; correct pixel resumes 2 edges after release, and anim_frame=0.
